// File: rtl/macrocell_pkg.sv
// Shared encodings for the CPLD macrocell: storage modes, PT role slots, select codes.
// Pure definitions; no logic, no latency, no flow control.
package macrocell_pkg;

  typedef enum logic [1:0] {
    MODE_COMB = 2'b00,
    MODE_D    = 2'b01,
    MODE_T    = 2'b10,
    MODE_DCE  = 2'b11
  } mode_e;

  localparam int PT_CLK = 0;
  localparam int PT_AR  = 1;
  localparam int PT_AP  = 2;
  localparam int PT_CE  = 3;
  localparam int PT_OE  = 4;

  // ar_sel is a two-bit enable vector: bit 0 enables gclr, bit 1 enables pt1.
  localparam int AR_BIT_GCLR = 0;
  localparam int AR_BIT_PT   = 1;

  // oe_sel codes below N_GOE+2; the pt4 code depends on N_GOE and lives in the top.
  localparam int OE_OFF      = 0;
  localparam int OE_ON       = 1;
  localparam int OE_GOE_BASE = 2;

endpackage

// File: rtl/product_term.sv
// One product term: AND of the literals selected by its fuse slice; empty slice gives 0.
// Purely combinational, zero latency; no flow control.
module product_term #(
  parameter int N_UIM = 40,
  parameter int N_FLB = 16
) (
  input  logic [2*(N_UIM+N_FLB)-1:0] map,
  input  logic [N_UIM-1:0]           uim,
  input  logic [N_FLB-1:0]           flb,
  output logic                       term
);
  localparam int N_IN = N_UIM + N_FLB;

  logic [N_IN-1:0] in_vec;
  assign in_vec = {flb, uim};

  // map[2j] includes input j true, map[2j+1] includes it complemented.
  always_comb begin
    term = |map;
    for (int j = 0; j < N_IN; j++) begin
      if ((map[2*j] & ~in_vec[j]) | (map[2*j+1] & in_vec[j])) begin
        term = 1'b0;
      end
    end
  end

endmodule

// File: rtl/macrocell_n.sv
// CPLD macrocell: N_PT product terms into OR/XOR sum with cascade, D/T/CE storage, AR/AP.
// Combinational outputs zero latency, q updates one clk later; static fuses, no flow control.
module macrocell_n
  import macrocell_pkg::*;
#(
  parameter int N_UIM  = 40,
  parameter int N_FLB  = 16,
  parameter int N_PT   = 5,
  parameter int N_GOE  = 6,
  parameter int N_GCLK = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PT*2*(N_UIM+N_FLB)-1:0]   pt_map,
  input  logic [N_PT-1:0]                   sum_mask,
  input  logic                              cas_en,
  input  logic                              casout_en,
  input  logic                              xor_inv,
  input  logic [1:0]                        mode,
  input  logic [$clog2(N_GCLK+1)-1:0]       clk_sel,
  input  logic [1:0]                        ar_sel,
  input  logic                              ap_en,
  input  logic [$clog2(N_GOE+3)-1:0]        oe_sel,
  input  logic                              o_sel,
  input  logic                              fb_sel,
  input  logic [N_UIM-1:0]                  uim,
  input  logic [N_FLB-1:0]                  in_flb,
  input  logic [N_GOE-1:0]                  goe,
  input  logic [N_GCLK-1:0]                 gclk,
  input  logic                              casin,
  input  logic                              gclr,
  output logic                              pad,
  output logic                              pad_oe,
  output logic                              mc_fb,
  output logic                              mc_flb,
  output logic                              casout,
  output logic                              q
);
  localparam int PT_W  = 2 * (N_UIM + N_FLB);
  localparam int OE_PT = N_GOE + 2;

  mode_e           mode_v;
  logic [N_PT-1:0] pt;
  logic [N_PT-1:0] role_mask;
  logic            sum, d, src, clk_edge, ar, ap;
  logic            q_d, q_q, prev_d, prev_q;

  assign mode_v = mode_e'(mode);

  for (genvar i = 0; i < N_PT; i++) begin : g_pt
    product_term #(.N_UIM(N_UIM), .N_FLB(N_FLB)) u_pt (
      .map  (pt_map[i*PT_W +: PT_W]),
      .uim  (uim),
      .flb  (in_flb),
      .term (pt[i])
    );
  end

  // A PT claimed for a control role never leaks into the sum, whatever sum_mask says.
  always_comb begin
    role_mask         = '0;
    role_mask[PT_CLK] = (int'(clk_sel) == N_GCLK);
    role_mask[PT_AR]  = ar_sel[AR_BIT_PT];
    role_mask[PT_AP]  = ap_en;
    role_mask[PT_CE]  = (mode_v == MODE_DCE);
    role_mask[PT_OE]  = (int'(oe_sel) == OE_PT);
  end

  assign sum    = (|(pt & sum_mask & ~role_mask)) | (cas_en & casin);
  assign casout = casout_en & sum;
  assign d      = (sum & ~casout_en) ^ xor_inv;

  always_comb begin
    src = 1'b0;
    for (int k = 0; k < N_GCLK; k++) begin
      if (int'(clk_sel) == k) src = gclk[k];
    end
    if (int'(clk_sel) == N_GCLK) src = pt[PT_CLK];
  end

  assign clk_edge = src & ~prev_q;
  assign ar = (ar_sel[AR_BIT_GCLR] & gclr) | (ar_sel[AR_BIT_PT] & pt[PT_AR]);
  assign ap = ap_en & pt[PT_AP];

  always_comb begin
    prev_d = src;
    q_d    = q_q;
    if (ar) begin
      q_d = 1'b0;
    end else if (ap) begin
      q_d = 1'b1;
    end else if (clk_edge && (mode_v != MODE_DCE || pt[PT_CE])) begin
      q_d = (mode_v == MODE_T) ? (q_q ^ d) : d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    pad_oe = 1'b0;
    if (int'(oe_sel) == OE_ON) pad_oe = 1'b1;
    for (int k = 0; k < N_GOE; k++) begin
      if (int'(oe_sel) == OE_GOE_BASE + k) pad_oe = goe[k];
    end
    if (int'(oe_sel) == OE_PT) pad_oe = pt[PT_OE];
    if (int'(oe_sel) == OE_OFF) pad_oe = 1'b0;
  end

  assign q      = q_q;
  assign pad    = o_sel ? d : q_q;
  assign mc_fb  = fb_sel ? d : q_q;
  assign mc_flb = ~mc_fb;

endmodule

// File: doc/macrocell_n.md
# macrocell_n

Parametrised next-generation CPLD macrocell for the cycle-based simulator: N product terms over a configurable UIM/FLB input space, an OR/XOR sum with cascade in/out, and a storage element supporting D, T and clock-enabled D modes. Selectable global or product-term clocks are modelled as rising-edge events sampled on the simulator clock, with AR/AP priority. It replaces the fixed 5-PT macrocell inside each logic block; the config ports are static fuse-map bits.

## Interface
- N_UIM, 40, UIM inputs per product term
- N_FLB, 16, foldback inputs per product term
- N_PT, 5, product terms (5..16); pt0..pt4 have fixed secondary roles
- N_GOE, 6, global output enables
- N_GCLK, 3, global clocks
- clk  in  1  simulator clock; the only clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset
- pt_map  in  N_PT*2*(N_UIM+N_FLB)  per PT, per input: [true, complement] include bits; 1 = term ANDed in
- sum_mask  in  N_PT  PT i contributes to OR sum
- cas_en  in  1  OR casin into sum
- casout_en  in  1  route sum to casout; storage/comb path then sees 0
- xor_inv  in  1  invert sum
- mode  in  2  00 comb, 01 D, 10 T, 11 D with CE=pt3
- clk_sel  in  $clog2(N_GCLK+1)  0..N_GCLK-1 gclk[k]; N_GCLK = pt0
- ar_sel  in  2  00 none, 01 gclr, 10 pt1, 11 gclr|pt1
- ap_en  in  1  pt2 is async preset
- oe_sel  in  $clog2(N_GOE+3)  0 off, 1 on, 2..N_GOE+1 goe[k-2], N_GOE+2 pt4
- o_sel, fb_sel  in  1 each  0 = register q, 1 = combinational d
- uim  in  N_UIM;  in_flb  in  N_FLB;  goe  in  N_GOE;  gclk  in  N_GCLK;  casin  in  1;  gclr  in  1
- pad, pad_oe, mc_fb, mc_flb, casout, q  out  1 each

## Operation
- PT i = AND of selected literals; a PT with no bits set evaluates 0.
- Role PTs (pt0 clock if clk_sel=N_GCLK, pt1 if ar_sel[1], pt2 if ap_en, pt3 if mode=11, pt4 if oe_sel=N_GOE+2) are forced out of the sum regardless of sum_mask.
- sum = OR(masked PTs) | (cas_en & casin); casout = casout_en ? sum : 0; d = (casout_en ? 0 : sum) ^ xor_inv.
- Edge detect: src = selected clock source; prev <= src every cycle; edge = src & ~prev.
- Register update priority per cycle: rst → q=0, prev=0; else AR → q=0; else AP → q=1; else edge & (mode!=11 | pt3): mode 10 → q ^= d, else q = d; else hold.
- AR/AP are level-sensitive, re-applied every cycle held; AR beats AP; both beat edge.
- Mode 00: register still updates as D; o_sel/fb_sel choose what is visible.
- pad = o_sel ? d : q; pad_oe per oe_sel; mc_fb = fb_sel ? d : q; mc_flb = ~mc_fb.

## Timing
- Combinational paths (PT → d → pad/mc_fb/casout, oe) zero latency.
- q changes at the clk edge ending the cycle in which edge/AR/AP/rst is true; visible next cycle.
- Reset values: q=0, prev=0; pad, mc_fb, mc_flb, casout, pad_oe are combinational from q=0 and current inputs (e.g. o_sel=0 → pad=0).
- Source held high across rst: edge fires first cycle after rst drops (prev=0).
- clk_sel changed mid-run: prev holds old source's value; low→high mismatch yields one edge. Defined behaviour, not masked.
- Consecutive edges need src low ≥1 cycle; max q toggle rate = clk/2.

## Structure
- Package macrocell_pkg: mode encodings, PT role indices (PT_CLK=0, PT_AR=1, PT_AP=2, PT_CE=3, PT_OE=4), ar_sel and special oe_sel codes.
- Sub-module product_term (parameters N_UIM, N_FLB): one AND term from its slice of pt_map; generated N_PT times.

## Test plan
- D mode, clk_sel=0, pt0 = uim[0] in sum: uim[0]=1, gclk[0] 0→1 at cycle 5 → q=1 at cycle 6; gclk[0] held high cycles 6–9 → no further updates.
- T mode, d=1, gclk[0] toggles every 2 cycles for 8 cycles → q sequence 1,0,1,0; rst at cycle 4 → q=0 cycle 5, prev=0.
- ar_sel=01, ap_en=1, gclr=1 and pt2=1 together with an edge → q=0; drop gclr → q=1 next cycle.
- mode=11: edge with pt3=0 → q holds; edge with pt3=1 → q=d; pt3 never in sum despite sum_mask bit set.
- Cascade: casout_en=1, sum=1 → casout=1, d=xor_inv, pad (o_sel=1) follows xor_inv; second instance cas_en=1 takes casin → its d=1.
- oe_sel sweep: 0 → pad_oe=0; 1 → 1; 2 → goe[0]; N_GOE+2 → pt4, pt4 excluded from sum.
